// File: rtl/spi_slave_regs_bank.sv
// Shadowed configuration register bank for the SPI slave with burst-write pointer.
// Ports: sclk/rstn, addr_load/addr_in/wr_data/wr_data_valid (write side), commit,
//   rd_addr/rd_data (read), wr_ptr, dummy_cycles, wrap_length, cfg_flat,
//   cfg_update, dirty, wr_err. Optional: SPI_REGS_SHADOW_RDBACK_EN (read shadow).
module spi_slave_regs_bank #(
  parameter int          REG_SIZE     = 8,
  parameter int          NUM_REGS     = 8,
  parameter int          ADDR_W       = 3,
  parameter logic [7:0]  DUMMY_CYCLES = 8'h7
) (
  input  logic                         sclk,
  input  logic                         rstn,
  input  logic                         addr_load,
  input  logic [ADDR_W-1:0]            addr_in,
  input  logic [REG_SIZE-1:0]          wr_data,
  input  logic                         wr_data_valid,
  input  logic                         commit,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic [REG_SIZE-1:0]          rd_data,
  output logic [ADDR_W-1:0]            wr_ptr,
  output logic [7:0]                   dummy_cycles,
  output logic [15:0]                  wrap_length,
  output logic [NUM_REGS*REG_SIZE-1:0] cfg_flat,
  output logic                         cfg_update,
  output logic                         dirty,
  output logic                         wr_err
);

  localparam logic [ADDR_W:0] NREG = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(NUM_REGS - 1);
  localparam logic [REG_SIZE-1:0] RST0 = REG_SIZE'(DUMMY_CYCLES);

  logic [REG_SIZE-1:0] shadow [NUM_REGS];
  logic [REG_SIZE-1:0] active [NUM_REGS];

  logic [ADDR_W-1:0] ea;
  logic              ea_ok;
  logic              ea_last;
  logic [ADDR_W-1:0] nxt_ptr;

  assign ea      = addr_load ? addr_in : wr_ptr;
  assign ea_ok   = {1'b0, ea} < NREG;
  // >= last also catches an out-of-range pointer and restarts at 0
  assign ea_last = {1'b0, ea} >= LAST;
  assign nxt_ptr = ea_last ? '0 : ea + 1'b1;

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
      shadow[0]  <= RST0;
      active[0]  <= RST0;
      wr_ptr     <= '0;
      dirty      <= 1'b0;
      cfg_update <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      if (wr_data_valid)
        wr_ptr <= nxt_ptr;
      else if (addr_load)
        wr_ptr <= addr_in;

      // active takes the pre-edge shadow; a same-cycle write waits
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_data_valid && ea_ok && ea == ADDR_W'(k))
          shadow[k] <= wr_data;
        if (commit)
          active[k] <= shadow[k];
      end

      if (wr_data_valid && ea_ok)
        dirty <= 1'b1;
      else if (commit)
        dirty <= 1'b0;

      if (wr_data_valid && !ea_ok)
        wr_err <= 1'b1;
      else if (commit)
        wr_err <= 1'b0;

      cfg_update <= commit & dirty;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_addr == ADDR_W'(k)) begin
`ifdef SPI_REGS_SHADOW_RDBACK_EN
        rd_data = shadow[k];
`else
        rd_data = active[k];
`endif
      end
    end
  end

  assign dummy_cycles = active[0][7:0];
  assign wrap_length  = {active[2][7:0], active[1][7:0]};

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign cfg_flat[g*REG_SIZE +: REG_SIZE] = active[g];
  end

endmodule

// File: tb/tb_spi_slave_regs_bank.sv
// Directed self-checking bench for spi_slave_regs_bank.
// Two instances: default 8-register bank and a 5-register bank for the error path.
module tb_spi_slave_regs_bank;

  logic        sclk = 1'b0;
  logic        rstn;

  logic        addr_load, wr_data_valid, commit;
  logic [2:0]  addr_in, rd_addr;
  logic [7:0]  wr_data, rd_data;
  logic [2:0]  wr_ptr;
  logic [7:0]  dummy_cycles;
  logic [15:0] wrap_length;
  logic [63:0] cfg_flat;
  logic        cfg_update, dirty, wr_err;

  logic        addr_load5, wr_data_valid5, commit5;
  logic [2:0]  addr_in5, rd_addr5;
  logic [7:0]  wr_data5, rd_data5;
  logic [2:0]  wr_ptr5;
  logic [7:0]  dummy_cycles5;
  logic [15:0] wrap_length5;
  logic [39:0] cfg_flat5;
  logic        cfg_update5, dirty5, wr_err5;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_rb;

  always #5 sclk = ~sclk;

  spi_slave_regs_bank u_dut (
    .sclk(sclk), .rstn(rstn),
    .addr_load(addr_load), .addr_in(addr_in),
    .wr_data(wr_data), .wr_data_valid(wr_data_valid),
    .commit(commit), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_ptr(wr_ptr), .dummy_cycles(dummy_cycles),
    .wrap_length(wrap_length), .cfg_flat(cfg_flat),
    .cfg_update(cfg_update), .dirty(dirty), .wr_err(wr_err)
  );

  spi_slave_regs_bank #(.NUM_REGS(5)) u_dut5 (
    .sclk(sclk), .rstn(rstn),
    .addr_load(addr_load5), .addr_in(addr_in5),
    .wr_data(wr_data5), .wr_data_valid(wr_data_valid5),
    .commit(commit5), .rd_addr(rd_addr5), .rd_data(rd_data5),
    .wr_ptr(wr_ptr5), .dummy_cycles(dummy_cycles5),
    .wrap_length(wrap_length5), .cfg_flat(cfg_flat5),
    .cfg_update(cfg_update5), .dirty(dirty5), .wr_err(wr_err5)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    addr_load = 0; wr_data_valid = 0; commit = 0;
    addr_in = 0; rd_addr = 0; wr_data = 0;
    addr_load5 = 0; wr_data_valid5 = 0; commit5 = 0;
    addr_in5 = 0; rd_addr5 = 0; wr_data5 = 0;
    #12;
    chk("rst_dummy", 64'(dummy_cycles), 64'h07);
    chk("rst_wrap", 64'(wrap_length), 64'h0);
    chk("rst_ptr", 64'(wr_ptr), 64'h0);
    chk("rst_dirty", 64'(dirty), 64'h0);
    chk("rst_rd0", 64'(rd_data), 64'h07);
    chk("rst_upd", 64'(cfg_update), 64'h0);
    chk("rst_err", 64'(wr_err), 64'h0);
    @(negedge sclk);
    rstn = 1'b1;
    tick();

    // burst 0x34, 0x12 starting at reg 1
    addr_load = 1; addr_in = 3'd1; wr_data_valid = 1; wr_data = 8'h34;
    tick();
    addr_load = 0; wr_data = 8'h12;
    tick();
    wr_data_valid = 0;
    chk("burst_ptr", 64'(wr_ptr), 64'h3);
    chk("burst_dirty", 64'(dirty), 64'h1);
    chk("burst_wrap_pre", 64'(wrap_length), 64'h0);
    commit = 1;
    tick();
    commit = 0;
    chk("burst_wrap", 64'(wrap_length), 64'h1234);
    chk("burst_upd", 64'(cfg_update), 64'h1);
    chk("burst_dirty0", 64'(dirty), 64'h0);
    tick();
    chk("burst_upd_1cyc", 64'(cfg_update), 64'h0);

    // pointer wrap past reg 7
    addr_load = 1; addr_in = 3'd6; wr_data_valid = 1; wr_data = 8'hAA;
    tick();
    addr_load = 0; wr_data = 8'hBB;
    tick();
    wr_data = 8'hCC;
    tick();
    wr_data_valid = 0;
    chk("wrap_ptr", 64'(wr_ptr), 64'h1);
    commit = 1;
    tick();
    commit = 0;
    rd_addr = 3'd6; #1;
    chk("wrap_r6", 64'(rd_data), 64'hAA);
    rd_addr = 3'd7; #1;
    chk("wrap_r7", 64'(rd_data), 64'hBB);
    chk("wrap_dummy", 64'(dummy_cycles), 64'hCC);
    chk("wrap_flat", cfg_flat, 64'hBBAA_0000_0012_34CC);
    tick();

    // write + commit same cycle
    addr_load = 1; addr_in = 3'd3; wr_data_valid = 1; wr_data = 8'h55;
    commit = 1;
    tick();
    addr_load = 0; wr_data_valid = 0; commit = 0;
    rd_addr = 3'd3; #1;
    chk("sim_r3_old", 64'(rd_data), 64'h00);
    chk("sim_dirty", 64'(dirty), 64'h1);
    chk("sim_upd", 64'(cfg_update), 64'h0);
    commit = 1;
    tick();
    commit = 0;
    chk("sim_r3_new", 64'(rd_data), 64'h55);
    chk("sim_upd2", 64'(cfg_update), 64'h1);
    chk("sim_dirty0", 64'(dirty), 64'h0);
    commit = 1;
    tick();
    commit = 0;
    chk("b2b_upd", 64'(cfg_update), 64'h0);
    chk("b2b_r3", 64'(rd_data), 64'h55);

    // uncommitted readback
    addr_load = 1; addr_in = 3'd4; wr_data_valid = 1; wr_data = 8'h42;
    tick();
    addr_load = 0; wr_data_valid = 0;
    rd_addr = 3'd4; #1;
`ifdef SPI_REGS_SHADOW_RDBACK_EN
    exp_rb = 8'h42;
`else
    exp_rb = 8'h00;
`endif
    chk("rdback_r4", 64'(rd_data), 64'(exp_rb));
    commit = 1;
    tick();
    commit = 0;
    chk("rdback_r4_commit", 64'(rd_data), 64'h42);

    // error path on 5-register bank
    addr_load5 = 1; addr_in5 = 3'd6; wr_data_valid5 = 1; wr_data5 = 8'h99;
    tick();
    addr_load5 = 0; wr_data_valid5 = 0;
    chk("err_flag", 64'(wr_err5), 64'h1);
    chk("err_ptr", 64'(wr_ptr5), 64'h0);
    chk("err_dirty", 64'(dirty5), 64'h0);
    commit5 = 1;
    tick();
    commit5 = 0;
    chk("err_clr", 64'(wr_err5), 64'h0);
    chk("err_upd", 64'(cfg_update5), 64'h0);
    chk("err_flat", 64'(cfg_flat5), 64'h07);
    rd_addr5 = 3'd6; #1;
    chk("err_rd_oor", 64'(rd_data5), 64'h0);
    // last register wraps pointer to 0
    addr_load5 = 1; addr_in5 = 3'd4; wr_data_valid5 = 1; wr_data5 = 8'h77;
    tick();
    addr_load5 = 0; wr_data_valid5 = 0;
    chk("n5_last_ptr", 64'(wr_ptr5), 64'h0);
    chk("n5_last_err", 64'(wr_err5), 64'h0);

    // mid-burst reset
    addr_load = 1; addr_in = 3'd0; wr_data_valid = 1; wr_data = 8'h20;
    tick();
    addr_load = 0; wr_data_valid = 0;
    chk("mid_dirty1", 64'(dirty), 64'h1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_dummy", 64'(dummy_cycles), 64'h07);
    chk("mid_dirty", 64'(dirty), 64'h0);
    chk("mid_wrap", 64'(wrap_length), 64'h0);
    chk("mid_ptr", 64'(wr_ptr), 64'h0);
    @(negedge sclk);
    rstn = 1'b1;
    commit = 1;
    tick();
    commit = 0;
    chk("mid_shadow0", 64'(dummy_cycles), 64'h07);
    chk("mid_upd", 64'(cfg_update), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_slave_regs_bank.md
Name: spi_slave_regs_bank

Overview:
- Parametrised configuration register bank for the SPI slave, one generation on from the fixed 3-register file.
- Holds NUM_REGS registers of REG_SIZE bits, written through an auto-incrementing pointer so a single SPI command can burst-write consecutive registers.
- Writes land in shadow registers and are applied atomically to the active registers on a commit pulse, normally issued at end of transaction (CS deassert).
- Active registers drive the protocol FSM: dummy cycles, wrap length and a flat config bus.

Parameters:
- REG_SIZE, 8: register width in bits; must be >= 8.
- NUM_REGS, 8: number of registers; must be >= 3.
- ADDR_W, 3: pointer/address width; must satisfy 2**ADDR_W >= NUM_REGS.
- DUMMY_CYCLES, 8'h7: reset value of register 0 (shadow and active).

Ports:
- sclk  in  1  SPI clock; all state on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- addr_load  in  1  load write pointer from addr_in this cycle.
- addr_in  in  ADDR_W  start address for burst.
- wr_data  in  REG_SIZE  write data.
- wr_data_valid  in  1  write wr_data at current pointer, then advance pointer.
- commit  in  1  copy all shadow registers to active.
- rd_addr  in  ADDR_W  combinational read address.
- rd_data  out  REG_SIZE  read data.
- wr_ptr  out  ADDR_W  current write pointer.
- dummy_cycles  out  8  active[0][7:0].
- wrap_length  out  16  {active[2][7:0], active[1][7:0]}.
- cfg_flat  out  NUM_REGS*REG_SIZE  all active registers; reg k at bits [k*REG_SIZE +: REG_SIZE].
- cfg_update  out  1  one-cycle pulse: active registers changed by a commit.
- dirty  out  1  shadow has been written since the last commit.
- wr_err  out  1  sticky: write attempted at pointer >= NUM_REGS.

Behaviour:
- Reset (async, rstn=0):
  - shadow[0] and active[0] = DUMMY_CYCLES; all other shadow/active = 0.
  - wr_ptr = 0; dirty, cfg_update, wr_err = 0.
- Effective write address: ea = addr_load ? addr_in : wr_ptr.
- Pointer update, per cycle:
  - If wr_data_valid: wr_ptr <= (ea >= NUM_REGS-1) ? 0 : ea+1. This wraps after the last register and also recovers from an out-of-range pointer.
  - Else if addr_load: wr_ptr <= addr_in.
  - Else wr_ptr holds.
- Write:
  - wr_data_valid with ea < NUM_REGS: shadow[ea] <= wr_data; dirty <= 1.
  - wr_data_valid with ea >= NUM_REGS: no register changes; wr_err <= 1; pointer still advances per the rule above.
- Commit (commit=1):
  - All active[k] <= shadow[k] as registered before this edge.
  - A write in the same cycle updates shadow only. It reaches active on the next commit, and dirty stays 1.
  - Otherwise dirty <= 0.
  - wr_err <= 0 unless an out-of-range write occurs in the same cycle.
  - cfg_update asserts the cycle after commit, for exactly one cycle, only if dirty was 1 at the commit edge.
- Commit with dirty=0 is legal: active is unchanged and no cfg_update pulse.
- Back-to-back commits: second pulse behaves per the rules above (no cfg_update unless written between).
- Read:
  - rd_data = active[rd_addr], combinational, zero latency.
  - rd_addr >= NUM_REGS returns 0.
- Reset mid-burst: all state returns to reset values immediately; uncommitted shadow data is lost.
- Outputs dummy_cycles, wrap_length and cfg_flat derive from active only; they never glitch on writes.

Optional Feature:
- Macro SPI_REGS_SHADOW_RDBACK_EN.
- Defined: rd_data returns shadow[rd_addr], so a host can read back uncommitted writes. Out of range still returns 0.
- Undefined: rd_data returns active[rd_addr] as above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset -> dummy_cycles=0x07, wrap_length=0x0000, wr_ptr=0, dirty=0, rd_data@0=0x07.
- Burst: addr_load=1 with addr_in=1 and wr_data_valid=1 with data 0x34, then wr_data_valid with 0x12:
  - wr_ptr ends at 3; dirty=1; wrap_length still 0x0000.
  - commit -> wrap_length=0x1234 the next cycle; cfg_update=1 for one cycle; dirty=0.
- Wrap: with NUM_REGS=8, load addr 6, write 0xAA, 0xBB, 0xCC -> shadow[6]=0xAA, shadow[7]=0xBB, shadow[0]=0xCC; wr_ptr=1.
- Simultaneous write and commit:
  - Commit in the same cycle as a write of 0x55 to reg 3 -> active[3] keeps the old value; dirty stays 1.
  - Second commit -> active[3]=0x55 and cfg_update pulses.
- Error path: NUM_REGS=5, ADDR_W=3; load addr 6, write 0x99 -> no register changes; wr_err=1; wr_ptr=0. Commit -> wr_err=0; cfg_update=0 if nothing else was written.
- Mid-burst reset: write 0x20 to reg 0, assert rstn=0 before commit -> dummy_cycles=0x07, shadow[0]=0x07, dirty=0.
- Feature check: with SPI_REGS_SHADOW_RDBACK_EN, an uncommitted write of 0x42 to reg 4 reads back 0x42 on rd_addr=4; without the macro it reads 0x00.
